// File: rtl/scpu_pkg.sv
// ----------------------------------------------------------------------------
// scpu_pkg : shared opcode, state and datapath-select encodings for SCPU (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

package scpu_pkg;

    localparam logic [3:0] c_OP_NOP  = 4'h0;
    localparam logic [3:0] c_OP_LDI  = 4'h1;
    localparam logic [3:0] c_OP_LDA  = 4'h2;
    localparam logic [3:0] c_OP_STA  = 4'h3;
    localparam logic [3:0] c_OP_ADD  = 4'h4;
    localparam logic [3:0] c_OP_SUB  = 4'h5;
    localparam logic [3:0] c_OP_AND  = 4'h6;
    localparam logic [3:0] c_OP_OR   = 4'h7;
    localparam logic [3:0] c_OP_IN   = 4'h8;
    localparam logic [3:0] c_OP_OUT  = 4'h9;
    localparam logic [3:0] c_OP_JMP  = 4'hA;
    localparam logic [3:0] c_OP_JZ   = 4'hB;
    localparam logic [3:0] c_OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WAITIN = 3'd4,
        S_HALT   = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    localparam logic [2:0] c_ALU_ADD  = 3'd0;
    localparam logic [2:0] c_ALU_SUB  = 3'd1;
    localparam logic [2:0] c_ALU_AND  = 3'd2;
    localparam logic [2:0] c_ALU_OR   = 3'd3;
    localparam logic [2:0] c_ALU_PASS = 3'd4;

    localparam logic [1:0] c_SEL_ALU = 2'd0;
    localparam logic [1:0] c_SEL_MEM = 2'd1;
    localparam logic [1:0] c_SEL_EXT = 2'd2;
    localparam logic [1:0] c_SEL_IMM = 2'd3;

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op >= c_OP_LDA) && (op <= c_OP_OR);
    endfunction

    function automatic logic [2:0] alu_of(input logic [3:0] op);
        case (op)
            c_OP_ADD: return c_ALU_ADD;
            c_OP_SUB: return c_ALU_SUB;
            c_OP_AND: return c_ALU_AND;
            c_OP_OR:  return c_ALU_OR;
            default:  return c_ALU_PASS;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/scpu_timeout_cnt.sv
// ----------------------------------------------------------------------------
// scpu_timeout_cnt : 4-bit memory wait counter, flags the last allowed wait cycle (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module scpu_timeout_cnt #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam logic [3:0] c_LAST = 4'(LIMIT - 1);

    logic [3:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + 4'd1;
        end
    end

    // Combinational so the request is dropped after exactly LIMIT unacked cycles.
    assign expired = en & (r_count == c_LAST);

endmodule

`default_nettype wire

// File: rtl/scpu_ctrl.sv
// ----------------------------------------------------------------------------
// scpu_ctrl : multi-cycle control sequencer for the SCPU accumulator datapath (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module scpu_ctrl
    import scpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       ir,
    input  logic             zero,
    input  logic             mem_ack,
    input  logic             ext_valid,
    output logic             ir_load,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             addr_sel,
    output logic             mem_req,
    output logic             mem_we,
    output logic             acc_load,
    output logic [1:0]       acc_sel,
    output logic [2:0]       alu_op,
    output logic             out_load,
    output logic             ext_ack,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] retired
);

    state_t     r_state;
    logic [3:0] w_op;
    logic       w_ack;
    logic       w_expired;
    logic       w_unused;

    assign w_op     = ir[7:4];
    assign w_unused = ^ir[3:0];   // operand field is consumed by the datapath only
    assign w_ack    = mem_req & mem_ack;

    scpu_timeout_cnt #(
        .LIMIT (MEM_TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (~mem_req | mem_ack),
        .en      (mem_req & ~mem_ack),
        .expired (w_expired)
    );

    assign ir_load  = (r_state == S_FETCH) & w_ack;
    assign pc_inc   = ir_load;
    assign ext_ack  = (r_state == S_WAITIN) & ext_valid;
    assign acc_load = ((r_state == S_MEM) & w_ack & (w_op != c_OP_STA))
                    | ((r_state == S_EXEC) & (w_op == c_OP_LDI))
                    | ext_ack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_FETCH;
            pc_load  <= 1'b0;
            addr_sel <= 1'b0;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            acc_sel  <= c_SEL_ALU;
            alu_op   <= c_ALU_ADD;
            out_load <= 1'b0;
            halted   <= 1'b0;
            fault    <= 1'b0;
            retired  <= '0;
        end else begin
            pc_load  <= 1'b0;
            out_load <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    // Only reachable with mem_req low straight after reset.
                    if (!mem_req) begin
                        mem_req <= 1'b1;
                    end else if (w_ack) begin
                        r_state <= S_DECODE;
                        mem_req <= 1'b0;
                    end else if (w_expired) begin
                        r_state <= S_FAULT;
                        mem_req <= 1'b0;
                        fault   <= 1'b1;
                    end
                end
                S_DECODE: begin
                    if (is_mem_op(w_op)) begin
                        r_state  <= S_MEM;
                        mem_req  <= 1'b1;
                        addr_sel <= 1'b1;
                        mem_we   <= (w_op == c_OP_STA);
                        acc_sel  <= (w_op == c_OP_LDA) ? c_SEL_MEM : c_SEL_ALU;
                        alu_op   <= alu_of(w_op);
                    end else if (w_op == c_OP_IN) begin
                        r_state <= S_WAITIN;
                        acc_sel <= c_SEL_EXT;
                    end else begin
                        r_state  <= S_EXEC;
                        acc_sel  <= (w_op == c_OP_LDI) ? c_SEL_IMM : c_SEL_ALU;
                        out_load <= (w_op == c_OP_OUT);
                        pc_load  <= (w_op == c_OP_JMP) | ((w_op == c_OP_JZ) & zero);
                    end
                end
                S_MEM: begin
                    if (w_ack) begin
                        r_state  <= S_FETCH;
                        addr_sel <= 1'b0;
                        mem_we   <= 1'b0;
                        acc_sel  <= c_SEL_ALU;
                        alu_op   <= c_ALU_ADD;
                        retired  <= retired + 1'b1;
                    end else if (w_expired) begin
                        r_state  <= S_FAULT;
                        mem_req  <= 1'b0;
                        addr_sel <= 1'b0;
                        mem_we   <= 1'b0;
                        fault    <= 1'b1;
                    end
                end
                S_WAITIN: begin
                    if (ext_valid) begin
                        r_state <= S_FETCH;
                        mem_req <= 1'b1;
                        acc_sel <= c_SEL_ALU;
                        retired <= retired + 1'b1;
                    end
                end
                S_EXEC: begin
                    acc_sel <= c_SEL_ALU;
                    retired <= retired + 1'b1;
                    if (w_op == c_OP_HALT) begin
                        r_state <= S_HALT;
                        halted  <= 1'b1;
                    end else begin
                        r_state <= S_FETCH;
                        mem_req <= 1'b1;
                    end
                end
                S_HALT:  r_state <= S_HALT;
                S_FAULT: r_state <= S_FAULT;
                default: r_state <= S_FETCH;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_scpu_ctrl.sv
// ----------------------------------------------------------------------------
// tb_scpu_ctrl : self-checking bench for scpu_ctrl, directed table plus random programs (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module tb_scpu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  ir = 8'h00;
    logic        zero = 1'b0;
    logic        mem_ack = 1'b0;
    logic        ext_valid = 1'b0;
    logic        ir_load, pc_inc, pc_load, addr_sel, mem_req, mem_we;
    logic        acc_load, out_load, ext_ack, halted, fault;
    logic [1:0]  acc_sel;
    logic [2:0]  alu_op;
    logic [15:0] retired;

    scpu_ctrl #(.MEM_TIMEOUT(15), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .ir(ir), .zero(zero), .mem_ack(mem_ack),
        .ext_valid(ext_valid), .ir_load(ir_load), .pc_inc(pc_inc),
        .pc_load(pc_load), .addr_sel(addr_sel), .mem_req(mem_req),
        .mem_we(mem_we), .acc_load(acc_load), .acc_sel(acc_sel),
        .alu_op(alu_op), .out_load(out_load), .ext_ack(ext_ack),
        .halted(halted), .fault(fault), .retired(retired)
    );

    always #5 clk = ~clk;

    localparam logic [10:0] IRL  = 11'h400;
    localparam logic [10:0] PCI  = 11'h200;
    localparam logic [10:0] PCL  = 11'h100;
    localparam logic [10:0] ASEL = 11'h080;
    localparam logic [10:0] REQ  = 11'h040;
    localparam logic [10:0] WE   = 11'h020;
    localparam logic [10:0] ACC  = 11'h010;
    localparam logic [10:0] OUT  = 11'h008;
    localparam logic [10:0] EXT  = 11'h004;
    localparam logic [10:0] HLT  = 11'h002;
    localparam logic [10:0] FLT  = 11'h001;

    logic [10:0] got_v;
    assign got_v = {ir_load, pc_inc, pc_load, addr_sel, mem_req, mem_we,
                    acc_load, out_load, ext_ack, halted, fault};

    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_ret = 16'd0;

    typedef struct {
        logic [7:0]  instr;
        int          fw;
        int          mw;
        logic        z;
        logic [10:0] done;
        logic [1:0]  dsel;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // One clock: drive inputs after the falling edge, then compare.
    task automatic cyc(input logic ma, input logic ev, input logic [10:0] want,
                       input logic [1:0] wsel, input logic [3:0] op, input string name);
        @(negedge clk);
        mem_ack   = ma;
        ext_valid = ev;
        #1;
        chk({name, " outs"}, 32'(got_v), 32'(want));
        chk({name, " retired"}, 32'(retired), 32'(exp_ret));
        if ((want & ACC) != 11'd0) begin
            chk({name, " acc_sel"}, 32'(acc_sel), 32'(wsel));
            if (op >= 4'd4 && op <= 4'd7)
                chk({name, " alu_op"}, 32'(alu_op), 32'(op - 4'd4));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst     = 1'b0;
        mem_ack = 1'b1;
        #1;
        chk("reset_async outs", 32'(got_v), 32'd0);
        chk("reset_async retired", 32'(retired), 32'd0);
        exp_ret = 16'd0;
        @(negedge clk);
        #1;
        chk("reset_held outs", 32'(got_v), 32'd0);
        rst = 1'b1;
    endtask

    // Walks one instruction through the expected per-cycle output shape.
    task automatic do_instr(input logic [7:0] instr, input int fw, input int mw,
                            input logic z, input logic [10:0] done, input logic [1:0] dsel);
        logic [3:0]  op;
        logic [10:0] base;
        op = instr[7:4];
        for (int i = 0; i < fw; i++) cyc(1'b0, rb(), REQ, 2'd0, 4'd0, "fetch_wait");
        cyc(1'b1, rb(), REQ | IRL | PCI, 2'd0, 4'd0, "fetch_ack");
        ir   = instr;
        zero = z;
        cyc(rb(), rb(), 11'd0, 2'd0, 4'd0, "decode");
        if (op >= 4'd2 && op <= 4'd7) begin
            base = REQ | ASEL | ((op == 4'd3) ? WE : 11'd0);
            for (int i = 0; i < mw; i++) cyc(1'b0, rb(), base, 2'd0, 4'd0, "mem_wait");
            cyc(1'b1, rb(), base | done, dsel, op, "mem_done");
        end else if (op == 4'd8) begin
            for (int i = 0; i < mw; i++) cyc(rb(), 1'b0, 11'd0, 2'd0, 4'd0, "wait_in");
            cyc(rb(), 1'b1, done, dsel, op, "in_done");
        end else begin
            cyc(rb(), rb(), done, dsel, op, "exec");
        end
        exp_ret = exp_ret + 16'd1;
    endtask

    function automatic logic [10:0] model_done(input logic [3:0] op, input logic z);
        case (op)
            4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7: return ACC;
            4'd8:  return ACC | EXT;
            4'd9:  return OUT;
            4'd10: return PCL;
            4'd11: return z ? PCL : 11'd0;
            default: return 11'd0;
        endcase
    endfunction

    function automatic logic [1:0] model_sel(input logic [3:0] op);
        case (op)
            4'd1: return 2'd3;
            4'd2: return 2'd1;
            4'd8: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    vec_t tbl[14];

    initial begin
        tbl = '{
            '{8'h15, 0,  0, 1'b0, ACC,       2'd3},
            '{8'h43, 0,  4, 1'b0, ACC,       2'd0},
            '{8'hB7, 0,  0, 1'b0, 11'd0,     2'd0},
            '{8'hB7, 0,  0, 1'b1, PCL,       2'd0},
            '{8'h80, 0, 10, 1'b0, ACC | EXT, 2'd2},
            '{8'hA3, 2,  0, 1'b0, PCL,       2'd0},
            '{8'h90, 1,  0, 1'b0, OUT,       2'd0},
            '{8'h3C, 14, 14, 1'b0, 11'd0,    2'd0},
            '{8'h2F, 0, 14, 1'b0, ACC,       2'd1},
            '{8'h51, 3,  1, 1'b0, ACC,       2'd0},
            '{8'hC0, 0,  0, 1'b1, 11'd0,     2'd0},
            '{8'h00, 0,  0, 1'b0, 11'd0,     2'd0},
            '{8'h64, 0,  2, 1'b0, ACC,       2'd0},
            '{8'h71, 5,  0, 1'b0, ACC,       2'd0}
        };

        do_reset();
        foreach (tbl[i]) do_instr(tbl[i].instr, tbl[i].fw, tbl[i].mw, tbl[i].z, tbl[i].done, tbl[i].dsel);

        do_instr(8'hF0, 0, 0, 1'b0, 11'd0, 2'd0);
        for (int i = 0; i < 20; i++) cyc(rb(), rb(), HLT, 2'd0, 4'd0, "halted");

        // Fetch never acknowledged.
        do_reset();
        for (int i = 0; i < 15; i++) cyc(1'b0, rb(), REQ, 2'd0, 4'd0, "fetch_timeout");
        for (int i = 0; i < 5; i++) cyc(rb(), rb(), FLT, 2'd0, 4'd0, "fault_fetch");

        // Operand access never acknowledged.
        do_reset();
        cyc(1'b1, 1'b0, REQ | IRL | PCI, 2'd0, 4'd0, "lda_fetch");
        ir = 8'h2A;
        cyc(1'b0, 1'b0, 11'd0, 2'd0, 4'd0, "lda_decode");
        for (int i = 0; i < 15; i++) cyc(1'b0, rb(), REQ | ASEL, 2'd0, 4'd0, "mem_timeout");
        for (int i = 0; i < 5; i++) cyc(rb(), rb(), FLT, 2'd0, 4'd0, "fault_mem");

        // Reset landing in the middle of an operand wait.
        do_reset();
        cyc(1'b1, 1'b0, REQ | IRL | PCI, 2'd0, 4'd0, "add_fetch");
        ir = 8'h43;
        cyc(1'b0, 1'b0, 11'd0, 2'd0, 4'd0, "add_decode");
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, REQ | ASEL, 2'd0, 4'd0, "add_wait");
        do_reset();

        for (int n = 0; n < 250; n++) begin
            logic [3:0] op;
            logic       z;
            int         fw, mw;
            op = 4'($urandom_range(0, 14));
            z  = rb();
            fw = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 14) : $urandom_range(0, 2);
            mw = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 14) : $urandom_range(0, 2);
            do_instr({op, 4'($urandom)}, fw, mw, z, model_done(op, z), model_sel(op));
        end
        do_instr(8'hF3, 1, 0, 1'b0, 11'd0, 2'd0);
        for (int i = 0; i < 4; i++) cyc(rb(), rb(), HLT, 2'd0, 4'd0, "halted_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
